pattern_player: RTL and testbench

- Sequencer directly downstream of the output-function pattern RAM.
- On start, walks RAM addresses 0..num_entries-1 through the RAM read port and captures each word into a registered output pattern, e.g. an LED bank.
- Each captured pattern is held for a programmable number of cycles.
- Plays once or loops; can be aborted at any time.

---
 rtl/pattern_player.sv | 90 +++++++++
 tb/tb_pattern_player.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_player.sv
// pattern_player: walks pattern RAM addresses and holds each captured word for a programmable time.
module pattern_player #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 7,
  parameter int CNTW   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [AWIDTH:0]   num_entries,
  input  logic [CNTW-1:0]   hold_cycles,
  output logic              rden,
  output logic [AWIDTH-1:0] rdaddr,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic [DWIDTH-1:0] pattern,
  output logic              pattern_strobe,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, READ, CAPTURE, HOLD} state_t;
  localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};
  state_t state;
  logic [AWIDTH-1:0] addr, last, last_n;
  logic [CNTW-1:0] cnt, hold_eff;
  logic loop;
  // counts above the RAM depth clamp to the full depth, i.e. last address all ones
  assign last_n = num_entries >= DEPTH ? '1 : num_entries[AWIDTH-1:0] - AWIDTH'(1);
  assign rdaddr = addr;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      last <= '0;
      cnt <= '0;
      hold_eff <= '0;
      loop <= 1'b0;
      rden <= 1'b0;
      pattern <= '0;
      pattern_strobe <= 1'b0;
      done <= 1'b0;
    end else begin
      pattern_strobe <= 1'b0;
      done <= 1'b0;
      if (state != IDLE && stop) begin
        state <= IDLE;
        rden <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start && !stop) begin
            if (num_entries != '0) begin
              loop <= loop_en;
              last <= last_n;
              hold_eff <= hold_cycles == '0 ? CNTW'(1) : hold_cycles;
              addr <= '0;
              rden <= 1'b1;
              state <= READ;
            end else begin
              done <= 1'b1;
            end
          end
          READ: begin
            rden <= 1'b0;
            state <= CAPTURE;
          end
          CAPTURE: begin
            pattern <= ram_dout;
            pattern_strobe <= 1'b1;
            cnt <= CNTW'(1);
            state <= HOLD;
          end
          HOLD: if (cnt == hold_eff) begin
            if (addr == last && !loop) begin
              done <= 1'b1;
              state <= IDLE;
            end else begin
              addr <= addr == last ? '0 : addr + AWIDTH'(1);
              rden <= 1'b1;
              state <= READ;
            end
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pattern_player.sv
// tb_pattern_player: randomized and directed playback checked by a scoreboard fed from a timing model.
module tb_pattern_player;
  localparam int DW = 16, AW = 7, CW = 32;
  logic clk = 0, reset = 1, start = 0, stop = 0, loop_en = 0;
  logic [AW:0] num_entries = '0;
  logic [CW-1:0] hold_cycles = '0;
  logic rden, pattern_strobe, busy, done;
  logic [AW-1:0] rdaddr;
  logic [DW-1:0] ram_dout = '0, pattern;
  logic [DW-1:0] mem [128];
  typedef struct {logic [DW-1:0] d; int t;} exp_t;
  exp_t pq[$], e_cur;
  int dq[$];
  int cyc = 0, tests = 0, fails = 0, rden_cnt = 0, max_addr = -1, lim = 128, c0 = 0;

  pattern_player #(.DWIDTH(DW), .AWIDTH(AW), .CNTW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .num_entries(num_entries), .hold_cycles(hold_cycles), .rden(rden), .rdaddr(rdaddr),
    .ram_dout(ram_dout), .pattern(pattern), .pattern_strobe(pattern_strobe),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rden) ram_dout <= mem[rdaddr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: every strobe/done must match the next scoreboard entry in value and cycle
  always @(negedge clk) if (!reset) begin
    if (pattern_strobe) begin
      if (pq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected strobe: pattern %h at cycle %0d, none expected", pattern, cyc);
      end else begin
        e_cur = pq.pop_front();
        chk("pattern", pattern, e_cur.d);
        chk("strobe cycle", cyc, e_cur.t);
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected done at cycle %0d, none expected", cyc);
      end else chk("done cycle", cyc, dq.pop_front());
    end
    if (rden) begin
      rden_cnt++;
      if (int'(rdaddr) > max_addr) max_addr = int'(rdaddr);
      if (int'(rdaddr) >= lim) begin
        tests++; fails++;
        $display("FAIL rdaddr range: got %0d, limit %0d", rdaddr, lim - 1);
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  // issue a start and push the model's expected strobes (cnt of them) and done pulse
  task automatic play(input int n, input int h, input bit lp, input int cnt, output int c);
    int nc, he;
    nc = n > 128 ? 128 : n;
    he = h == 0 ? 1 : h;
    @(posedge clk); #1;
    c = cyc;
    start = 1; num_entries = (AW+1)'(n); hold_cycles = CW'(h); loop_en = lp;
    lim = nc == 0 ? 1 : nc;
    for (int k = 0; k < cnt; k++) pq.push_back('{mem[k % nc], c + 3 + k * (he + 2)});
    if (nc == 0) dq.push_back(c + 1);
    else if (!lp && cnt == nc) dq.push_back(c + 3 + (nc - 1) * (he + 2) + he);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic pulse_stop();
    stop = 1; @(posedge clk); #1; stop = 0;
  endtask

  task automatic drained(input string name);
    wait_cyc(cyc + 3);
    chk(name, 64'(pq.size() + dq.size()), 0);
  endtask

  task automatic check_zero();
    chk("reset pattern", pattern, 0);
    chk("reset strobe", pattern_strobe, 0);
    chk("reset done", done, 0);
    chk("reset busy", busy, 0);
    chk("reset rden", rden, 0);
    chk("reset rdaddr", rdaddr, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n, h, cnt;
    bit lp;
    mem[0] = 16'h0001; mem[1] = 16'hAAAA; mem[2] = 16'h5555; mem[3] = 16'hFFFF;
    for (int i = 4; i < 128; i++) mem[i] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_zero();
    reset = 0;
    // play once: 4 entries, hold 3
    play(4, 3, 0, 4, c0);
    wait_cyc(c0 + 3 + 15 + 3 + 2);
    chk("once final pattern", pattern, 16'hFFFF);
    chk("once busy", busy, 0);
    drained("once drained");
    // loop 2 entries, hold 1, stop after six strobes
    max_addr = -1;
    play(2, 1, 1, 6, c0);
    wait_cyc(c0 + 3 + 5 * 3);
    pulse_stop();
    chk("loop busy after stop", busy, 0);
    chk("loop pattern kept", pattern, 16'hAAAA);
    chk("loop max rdaddr", max_addr, 1);
    drained("loop drained");
    // stop during CAPTURE of entry 2
    play(4, 3, 0, 2, c0);
    wait_cyc(c0 + 3 + 2 * 5 - 1);
    pulse_stop();
    chk("stop busy", busy, 0);
    chk("stop pattern kept", pattern, 16'hAAAA);
    drained("stop drained");
    // replay from 0, hold 0 behaves as 1
    play(4, 0, 0, 4, c0);
    wait_cyc(c0 + 3 + 9 + 1 + 2);
    drained("hold0 drained");
    // asynchronous reset in HOLD
    play(4, 3, 0, 4, c0);
    wait_cyc(c0 + 4);
    #2 reset = 1;
    #1 check_zero();
    pq.delete(); dq.delete();
    @(posedge clk); #1;
    reset = 0;
    play(2, 1, 0, 2, c0);
    wait_cyc(c0 + 3 + 3 + 1 + 2);
    chk("after reset pattern", pattern, 16'hAAAA);
    drained("after reset drained");
    // zero entries
    rden_cnt = 0;
    play(0, 2, 0, 0, c0);
    wait_cyc(c0 + 4);
    chk("n0 rden count", rden_cnt, 0);
    chk("n0 busy", busy, 0);
    drained("n0 drained");
    // clamp 200 -> 128
    max_addr = -1;
    play(200, 0, 0, 128, c0);
    wait_cyc(c0 + 3 + 127 * 3 + 1 + 2);
    chk("clamp max rdaddr", max_addr, 127);
    drained("clamp drained");
    // start with stop stays idle
    rden_cnt = 0;
    @(posedge clk); #1;
    start = 1; stop = 1; num_entries = 4;
    @(posedge clk); #1;
    start = 0; stop = 0;
    chk("start+stop busy", busy, 0);
    wait_cyc(cyc + 4);
    chk("start+stop rden", rden_cnt, 0);
    // random playbacks with an ignored mid-run start
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 6);
      h = $urandom_range(0, 4);
      lp = 1'($urandom);
      cnt = lp ? $urandom_range(n, 2 * n + 2) : n;
      play(n, h, lp, cnt, c0);
      num_entries = 1;
      start = 1; @(posedge clk); #1; start = 0;
      wait_cyc(c0 + 3 + (cnt - 1) * ((h == 0 ? 1 : h) + 2));
      if (lp) pulse_stop();
      else wait_cyc(cyc + (h == 0 ? 1 : h) + 1);
      chk("rand final pattern", pattern, mem[(cnt - 1) % n]);
      drained("rand drained");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
